uart_tx_arbiter: RTL and testbench

Shares the board's single UART transmitter between several byte sources (CPU putchar path, finish-message generator, debug sources). It performs round-robin arbitration among requesters presenting bytes and serializes each granted byte as an 8N1 frame on `tx`. It sits inside the device block, between the MMIO decode and the board `tx` pin. It replaces ad-hoc muxing of character sources ahead of the serializer.

---
 rtl/uart_tx_arbiter_pkg.sv | 15 +
 rtl/uart_tx_core.sv | 99 +++++++++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared device definitions for the UART transmit path: core states, default
// bit timing and line-terminator bytes.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int unsigned UART_BIT_TMR_DEFAULT = 10416;
  localparam logic [7:0]  UART_NL  = 8'h0A;
  localparam logic [7:0]  UART_NUL = 8'h00;

  function automatic logic is_line_end(input logic [7:0] b);
    return (b == UART_NL) || (b == UART_NUL);
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: accepts one byte in IDLE, then drives start, 8 data bits
// (LSB first) and stop, each lasting BIT_TMR_MAX+1 cycles.
module uart_tx_core
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned BIT_TMR_MAX = UART_BIT_TMR_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned TMR_W =
    ($clog2(BIT_TMR_MAX + 1) > 14) ? $clog2(BIT_TMR_MAX + 1) : 14;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BIT_TMR_MAX);

  uart_state_t      state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tmr_done;

  assign tmr_done = (tmr_q == TMR_LAST);

  // Ready is gated by resetn so nothing is offered while reset is held.
  always_comb begin
    in_ready = resetn && (state_q == IDLE);
    busy     = (state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TMR_W'(1);
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (in_valid && in_ready) begin
          state_d = START;
          data_d  = in_data;
          bit_d   = '0;
        end
      end
      START: begin
        if (tmr_done) begin
          state_d = DATA;
          tmr_d   = '0;
        end
      end
      DATA: begin
        if (tmr_done) begin
          tmr_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (tmr_done) begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Line level is decoded from state so an async reset returns it high at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = data_q[bit_q];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Define UART_ARB_LOCK_EN to hold the grant on one requester until it ends a line.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned BIT_TMR_MAX = UART_BIT_TMR_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       tx
);

  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam logic [IDW:0] NREQ = (IDW + 1)'(NUM_REQ);

  logic [IDW-1:0]     rr_q, rr_d, gid_q, gid_d, sel;
  logic [IDW:0]       idx, nxt;
  logic               found, core_ready, accept;
  logic [NUM_REQ-1:0] eligible;
  logic [7:0]         sel_data;

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;

  // While locked, only the last granted requester (gid_q) may win.
  always_comb begin
    eligible = req_valid;
    if (lock_q) begin
      eligible        = '0;
      eligible[gid_q] = req_valid[gid_q];
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (accept) lock_d = !is_line_end(sel_data);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lock_q <= 1'b0;
    else         lock_q <= lock_d;
  end
`else
  always_comb eligible = req_valid;
`endif

  // First eligible requester at or after rr_q, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (IDW + 1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx[IDW-1:0]]) begin
        found = 1'b1;
        sel   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_data  = req_data[{sel, 3'b000} +: 8];
    accept    = found && core_ready;
    req_ready = '0;
    if (accept) req_ready[sel] = 1'b1;
    nxt = {1'b0, sel} + (IDW + 1)'(1);
    if (nxt >= NREQ) nxt = '0;
    rr_d  = accept ? nxt[IDW-1:0] : rr_q;
    gid_d = accept ? sel : gid_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q  <= '0;
      gid_q <= '0;
    end else begin
      rr_q  <= rr_d;
      gid_q <= gid_d;
    end
  end

  assign grant_id = gid_q;

  uart_tx_core #(
    .BIT_TMR_MAX(BIT_TMR_MAX)
  ) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (found),
    .in_data  (sel_data),
    .in_ready (core_ready),
    .busy     (busy),
    .tx       (tx)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=2, BIT_TMR_MAX=3) against a
// queue-based model of arbitration order and expected line waveform.
module tb_uart_tx_arbiter;

  localparam int N     = 2;
  localparam int TMR   = 3;
  localparam int BITP  = TMR + 1;
  localparam int FRAME = 10 * BITP;

  logic           clk = 1'b0;
  logic           resetn;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [0:0]     grant_id;
  logic           busy;
  logic           tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .BIT_TMR_MAX (TMR)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx        (tx)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rq [N][$];
  int         m_rr, m_gid;
  bit         m_lock;
  bit         txq[$];
  int         acc_id[$];
  int         acc_cyc[$];
  int         cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sel(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (m_lock && i != m_gid) continue;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (rq[i].size() > 0);
      req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_gid = 0; m_lock = 0; cyc = 0;
    txq.delete(); acc_id.delete(); acc_cyc.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = N'($urandom);
    req_data  = (N*8)'($urandom);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    model_reset();
    drive_inputs();
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  // One clock of model comparison plus requester handshake.
  task automatic step();
    logic [N-1:0] got_rdy, exp_rdy;
    bit           eb, et;
    int           s;
    logic [7:0]   b;
    @(negedge clk);
    eb = (txq.size() > 0);
    et = eb ? txq.pop_front() : 1'b1;
    check("tx", tx, et);
    check("busy", busy, eb);
    check("grant_id", grant_id, m_gid);
    exp_rdy = '0;
    s = model_sel(req_valid);
    if (!eb && s >= 0) exp_rdy[s] = 1'b1;
    got_rdy = req_ready;
    check("req_ready", got_rdy, exp_rdy);
    if (!eb && s >= 0) begin
      b     = rq[s][0];
      m_gid = s;
      m_rr  = (s + 1) % N;
`ifdef UART_ARB_LOCK_EN
      m_lock = !(b == 8'h0A || b == 8'h00);
`endif
      for (int j = 0; j < BITP; j++) txq.push_back(1'b0);
      for (int k = 0; k < 8; k++)
        for (int j = 0; j < BITP; j++) txq.push_back(b[k]);
      for (int j = 0; j < BITP; j++) txq.push_back(1'b1);
      acc_id.push_back(s);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (got_rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive_inputs();
    cyc++;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((pending() || txq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, (pending() || txq.size() > 0) ? 0 : 1, 1);
    step();
  endtask

  initial begin
    logic [7:0] b;
    int         exp_order [4];

    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    m_rr = 0; m_gid = 0; m_lock = 0; cyc = 0;

    // Reset with arbitrary inputs
    repeat (2) @(posedge clk);
    do_reset();

    // Single byte 0x48 from req0
    rq[0].push_back(8'h48);
    drive_inputs();
    run_until_done(FRAME + 20, "single_done");
    check("single_count", acc_id.size(), 1);
    check("single_id", acc_id[0], 0);
    check("single_first_cycle", acc_cyc[0], 0);

    // Contention: both requesters valid continuously
    do_reset();
    rq[0] = '{8'h41, 8'h41};
    rq[1] = '{8'h42, 8'h42};
    drive_inputs();
    run_until_done(4 * (FRAME + 1) + 20, "cont_done");
    exp_order = '{0, 1, 0, 1};
    check("cont_count", acc_id.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("cont_order%0d", k), acc_id[k], exp_order[k]);
    for (int k = 1; k < 4; k++) check($sformatf("cont_gap%0d", k), acc_cyc[k] - acc_cyc[k-1], FRAME + 1);

    // Reset during DATA bit 3 (bit 3 forced low so the async return is visible)
    do_reset();
    b = 8'($urandom) & 8'hF7;
    rq[0].push_back(b);
    drive_inputs();
    step();
    check("mid_accepted", acc_id.size(), 1);
    repeat (17) step();
    check("mid_bit3_low", tx, 0);
    resetn = 1'b0;
    #1;
    check("mid_async_tx", tx, 1);
    check("mid_async_busy", busy, 0);
    check("mid_async_ready", req_ready, 0);
    model_reset();
    rq[1].push_back(8'($urandom));
    drive_inputs();
    #1 resetn = 1'b1;
    run_until_done(FRAME + 20, "mid_done");
    check("mid_count", acc_id.size(), 1);
    check("mid_id", acc_id[0], 1);
    check("mid_first_cycle", acc_cyc[0], 0);

    // Line stream "ab\n" on req0 while req1 holds 0x5A
    do_reset();
    rq[0] = '{8'h61, 8'h62, 8'h0A};
    rq[1] = '{8'h5A};
    drive_inputs();
    run_until_done(4 * (FRAME + 1) + 20, "lock_done");
`ifdef UART_ARB_LOCK_EN
    exp_order = '{0, 0, 0, 1};
`else
    exp_order = '{0, 1, 0, 0};
`endif
    check("lock_count", acc_id.size(), 4);
    for (int k = 0; k < 4; k++) check($sformatf("lock_order%0d", k), acc_id[k], exp_order[k]);

    // Randomized streams; every stream ends with a newline so locks release
    for (int r = 0; r < 3; r++) begin
      int total;
      do_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len - 1; k++) begin
          if ($urandom_range(0, 3) == 0) rq[i].push_back($urandom_range(0, 1) ? 8'h0A : 8'h00);
          else                           rq[i].push_back(8'($urandom));
        end
        rq[i].push_back(8'h0A);
        total += len;
      end
      drive_inputs();
      run_until_done(total * (FRAME + 1) + 20, $sformatf("rand%0d_done", r));
      check($sformatf("rand%0d_count", r), acc_id.size(), total);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
